// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // All segments off (segments are active-low, ordered {g,f,e,d,c,b,a}).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_scan_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_7seg
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment scan driver: walks NUM_DIGITS common-anode digits,
// one digit per rising edge of the (asynchronous) scan square wave, with a
// dark gap of BLANK_CYCLES clocks before each digit to stop ghosting.
//
// load is a single-cycle strobe with no back-pressure: whenever load is high
// at a clock edge, value/dp are captured into the shadow register, in every
// state. The shadow only reaches the displayed copy at the start of a full
// sweep (wrap to digit 0, or leaving IDLE), so a sweep never mixes two values;
// a load on that very edge is forwarded straight into the displayed copy.
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int BLANK_CYCLES = 16,
  parameter  int LZ_BLANK     = 1,
  localparam int IDX_W        = $clog2(NUM_DIGITS),
  localparam int VAL_W        = 4 * NUM_DIGITS
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  scan_in,
  input  logic                  enable,
  input  logic                  load,
  input  logic [VAL_W-1:0]      value,
  input  logic [NUM_DIGITS-1:0] dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

  logic                  scan_s1, scan_s2, scan_s3;
  logic                  scan_edge;
  state_t                state;
  logic [CNT_W-1:0]      blank_cnt;
  logic [VAL_W-1:0]      shadow_val, disp_val, next_disp_val, upper_val;
  logic [NUM_DIGITS-1:0] shadow_dp, disp_dp, next_disp_dp;
  logic                  last_digit, lz_hide;
  logic [IDX_W-1:0]      idx_inc;
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg, drive_seg;
  logic [NUM_DIGITS-1:0] drive_an;

  // Two-stage synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scan_s1 <= 1'b0;
      scan_s2 <= 1'b0;
      scan_s3 <= 1'b0;
    end else begin
      scan_s1 <= scan_in;
      scan_s2 <= scan_s1;
      scan_s3 <= scan_s2;
    end
  end

  assign scan_edge = scan_s2 & ~scan_s3;

  // A load on the sweep-start edge bypasses the shadow.
  assign next_disp_val = load ? value : shadow_val;
  assign next_disp_dp  = load ? dp    : shadow_dp;

  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign idx_inc    = last_digit ? '0 : digit_idx + IDX_W'(1);

  // Current digit's nibble and everything above it (for leading-zero test).
  assign cur_nib   = disp_val[{digit_idx, 2'b00} +: 4];
  assign upper_val = disp_val >> {digit_idx, 2'b00};
  assign lz_hide   = (LZ_BLANK != 0) && (digit_idx != '0) && (upper_val == '0);

  hex_to_7seg u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  assign drive_seg = lz_hide ? SEG_BLANK : dec_seg;
  assign drive_an  = ~(NUM_DIGITS'(1) << digit_idx);

  // Shadow register: captures every load strobe.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp;
    end
  end

  // Scan FSM: blank timing, digit index, displayed copy and registered pins.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blank_cnt <= '0;
      digit_idx <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
      dp_n      <= 1'b1;
    end else if (!enable) begin
      state     <= IDLE;
      blank_cnt <= '0;
      digit_idx <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
      dp_n      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          an   <= '1;
          seg  <= SEG_BLANK;
          dp_n <= 1'b1;
          if (scan_edge) begin
            state     <= BLANK;
            blank_cnt <= '0;
            digit_idx <= '0;
            disp_val  <= next_disp_val;
            disp_dp   <= next_disp_dp;
          end
        end
        BLANK: begin
          if (blank_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state <= DRIVE;
            an    <= drive_an;
            seg   <= drive_seg;
            dp_n  <= ~disp_dp[digit_idx];
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (scan_edge) begin
            state     <= BLANK;
            blank_cnt <= '0;
            digit_idx <= idx_inc;
            an        <= '1;
            seg       <= SEG_BLANK;
            dp_n      <= 1'b1;
            if (last_digit) begin
              disp_val <= next_disp_val;
              disp_dp  <= next_disp_dp;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: directed scenarios with literal expectations,
// then randomized scan/load/enable traffic, all checked every cycle against a
// behavioural model of what the display pins should show.
module tb_seg_display_scan;

  localparam int NUM_DIGITS = 4;
  localparam int BLANK      = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_in;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic [1:0]  state_dbg;

  int checks_total  = 0;
  int checks_passed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  seg_display_scan #(
    .NUM_DIGITS   (NUM_DIGITS),
    .BLANK_CYCLES (BLANK),
    .LZ_BLANK     (1)
  ) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .scan_in   (scan_in),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .dp        (dp),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .digit_idx (digit_idx),
    .state_dbg (state_dbg)
  );

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned m_disp, m_shadow;
  logic [3:0]  m_disp_dp, m_shadow_dp;
  bit          m_on;
  int          m_digit, m_drive_at, cyc;
  bit          smp_q[$];
  bit          rise, was_drive;

  // A scan rise becomes visible to the scanner when the sample taken two
  // clocks ago is 1 and the one before it was 0. A digit becomes lit BLANK
  // clocks after the edge that selected it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 0; m_digit = 0; m_drive_at = 0; cyc = 0;
      m_disp = 0; m_disp_dp = '0; m_shadow = 0; m_shadow_dp = '0;
      smp_q = '{1'b0, 1'b0, 1'b0};
    end else begin
      cyc++;
      rise      = smp_q[1] && !smp_q[2];
      was_drive = m_on && (cyc - 1 >= m_drive_at);
      smp_q.push_front(scan_in);
      void'(smp_q.pop_back());
      if (!enable) begin
        m_on = 0; m_digit = 0;
      end else if (!m_on) begin
        if (rise) begin
          m_on = 1; m_digit = 0; m_drive_at = cyc + BLANK;
          m_disp    = load ? int'(value) : m_shadow;
          m_disp_dp = load ? dp : m_shadow_dp;
        end
      end else if (was_drive && rise) begin
        m_drive_at = cyc + BLANK;
        if (m_digit == NUM_DIGITS - 1) begin
          m_digit   = 0;
          m_disp    = load ? int'(value) : m_shadow;
          m_disp_dp = load ? dp : m_shadow_dp;
        end else begin
          m_digit++;
        end
      end
      if (load) begin
        m_shadow = value; m_shadow_dp = dp;
      end
    end
  end

  function automatic logic [13:0] model_expect();
    int unsigned upper;
    logic [3:0]  nib, e_an;
    logic [6:0]  e_seg;
    logic [1:0]  e_idx;
    e_idx = 2'(m_digit);
    if (!m_on || cyc < m_drive_at) return {4'hF, 7'h7F, 1'b1, e_idx};
    upper = m_disp >> (4 * m_digit);
    nib   = 4'(upper % 16);
    e_seg = (m_digit != 0 && upper == 0) ? 7'h7F : seg_tab[nib];
    e_an  = ~(4'b0001 << m_digit);
    return {e_an, e_seg, ~m_disp_dp[m_digit], e_idx};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1)
      check("cycle_model", {18'b0, an, seg, dp_n, digit_idx}, {18'b0, model_expect()});
  end

  // ---------------- drivers ----------------
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load = 1'b1; value = v; dp = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Raise scan_in and wait until a digit is lit; optionally add a second
  // rise during the blank gap and/or a load landing on the scanner edge.
  task automatic rise_and_wait(input bit extra, input bit ld_edge, input logic [15:0] lv,
                               output int lat, output int dark_at);
    scan_in = 1'b1; lat = 0; dark_at = -1;
    do begin
      @(negedge clk);
      lat++;
      if (ld_edge && lat == 2) begin load = 1'b1; value = lv; dp = 4'h0; end
      if (lat == 3) load = 1'b0;
      if (lat == 4) scan_in = 1'b0;
      if (extra && lat == 8) scan_in = 1'b1;
      if (extra && lat == 12) scan_in = 1'b0;
      if (dark_at < 0 && an == 4'hF) dark_at = lat;
    end while (!(lat > 3 && an != 4'hF) && lat < 60);
    scan_in = 1'b0;
    load = 1'b0;
    check("drive_timeout", 32'(lat < 60), 32'd1);
  endtask

  task automatic expect_digit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp_n, input logic [1:0] e_idx);
    check({name, "_an"},  32'(an),        32'(e_an));
    check({name, "_seg"}, 32'(seg),       32'(e_seg));
    check({name, "_dp"},  32'(dp_n),      32'(e_dp_n));
    check({name, "_idx"}, 32'(digit_idx), 32'(e_idx));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, dk, scnt, en_off;
    rst_n = 1'b0; scan_in = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp = '0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    expect_digit("reset", 4'hF, 7'h7F, 1'b1, 2'd0);
    check("reset_state", 32'(state_dbg), 32'd0);

    // Basic sweep of 16'h12AF.
    enable = 1'b1;
    do_load(16'h12AF, 4'h0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    check("first_latency", lat, 32'd19);
    expect_digit("sweep_d0", 4'b1110, 7'b0001110, 1'b1, 2'd0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    check("dark_after_3", dk, 32'd3);
    check("next_latency", lat, 32'd19);
    expect_digit("sweep_d1", 4'b1101, 7'b0001000, 1'b1, 2'd1);
    do_load(16'h1234, 4'h0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("tear_d2", 4'b1011, 7'b0100100, 1'b1, 2'd2);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("tear_d3", 4'b0111, 7'b1111001, 1'b1, 2'd3);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("wrap_d0", 4'b1110, 7'b0011001, 1'b1, 2'd0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("wrap_d1", 4'b1101, 7'b0110000, 1'b1, 2'd1);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    rise_and_wait(0, 0, 16'h0, lat, dk);

    // Leading-zero blanking with a decimal point on a blanked digit.
    do_load(16'h0005, 4'b0100);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("lz_d0", 4'b1110, 7'b0010010, 1'b1, 2'd0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("lz_d1", 4'b1101, 7'h7F, 1'b1, 2'd1);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("lz_d2", 4'b1011, 7'h7F, 1'b0, 2'd2);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("lz_d3", 4'b0111, 7'h7F, 1'b1, 2'd3);
    do_load(16'h0000, 4'h0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("zero_d0", 4'b1110, 7'b1000000, 1'b1, 2'd0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("zero_d1", 4'b1101, 7'h7F, 1'b1, 2'd1);

    // A second rise during the blank gap is dropped.
    rise_and_wait(1, 0, 16'h0, lat, dk);
    check("blank_drop_lat", lat, 32'd19);
    check("blank_drop_idx", 32'(digit_idx), 32'd2);

    // Disable mid-drive, then re-enable.
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    expect_digit("disable", 4'hF, 7'h7F, 1'b1, 2'd0);
    enable = 1'b1;
    rise_and_wait(0, 0, 16'h0, lat, dk);
    check("reenable_lat", lat, 32'd19);
    expect_digit("reenable_d0", 4'b1110, 7'b1000000, 1'b1, 2'd0);

    // Load on the wrap edge is forwarded straight to the display.
    do_load(16'h1111, 4'h0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    rise_and_wait(0, 1, 16'hBEEF, lat, dk);
    expect_digit("bypass_d0", 4'b1110, 7'b0001110, 1'b1, 2'd0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    expect_digit("bypass_d1", 4'b1101, 7'b0000110, 1'b1, 2'd1);

    // Asynchronous reset mid-drive.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_digit("async_rst", 4'hF, 7'h7F, 1'b1, 2'd0);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    expect_digit("post_rst", 4'hF, 7'h7F, 1'b1, 2'd0);
    rise_and_wait(0, 0, 16'h0, lat, dk);
    check("post_rst_lat", lat, 32'd19);
    expect_digit("post_rst_d0", 4'b1110, 7'b1000000, 1'b1, 2'd0);

    // Randomized traffic checked by the model every cycle.
    scnt = 0; en_off = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (scnt == 0) begin
        scan_in = ~scan_in;
        scnt = $urandom_range(1, 25);
      end else begin
        scnt--;
      end
      if ($urandom_range(0, 19) == 0) begin
        load  = 1'b1;
        value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp    = 4'($urandom);
      end
      if (en_off > 0) begin
        en_off--;
        if (en_off == 0) enable = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        en_off = $urandom_range(1, 6);
      end
    end
    @(negedge clk);
    load = 1'b0; enable = 1'b0; scan_in = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
